// File: rtl/colour_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : colour_pkg
//  Description : Shared widths, colour code constants and requester ids for
//                the colour LUT arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package colour_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 24;

    localparam logic [ADDR_W-1:0] BLACK   = 3'd0;
    localparam logic [ADDR_W-1:0] BLUE    = 3'd1;
    localparam logic [ADDR_W-1:0] GREEN   = 3'd2;
    localparam logic [ADDR_W-1:0] CYAN    = 3'd3;
    localparam logic [ADDR_W-1:0] RED     = 3'd4;
    localparam logic [ADDR_W-1:0] MAGENTA = 3'd5;
    localparam logic [ADDR_W-1:0] YELLOW  = 3'd6;
    localparam logic [ADDR_W-1:0] WHITE   = 3'd7;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/lut_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : lut_tag_pipe
//  Description : RD_LAT-deep shift register of {valid, id} tags that tracks
//                which requester owns each read in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module lut_tag_pipe
    import colour_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_valid,
    input  req_id_e push_id,
    output logic    last_valid,
    output req_id_e last_id,
    output logic    any_valid
);

    logic [RD_LAT-1:0] r_valid;
    req_id_e           r_id [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= push_valid;
            for (int i = 1; i < RD_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Ids carry no meaning without their valid bit, so they are not reset.
    always_ff @(posedge clk) begin
        r_id[0] <= push_id;
        for (int i = 1; i < RD_LAT; i++) begin
            r_id[i] <= r_id[i-1];
        end
    end

    assign last_valid = r_valid[RD_LAT-1];
    assign last_id    = r_id[RD_LAT-1];
    assign any_valid  = |r_valid;

endmodule
`default_nettype wire

// File: rtl/colour_lut_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : colour_lut_arbiter
//  Description : Round-robin arbiter sharing one colour->RGB lookup memory
//                between requesters A and B, routing results back by tag.
//  Revision    : 1.0  initial release
// ============================================================================
module colour_lut_arbiter #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              req_a_valid,
    input  logic [ADDR_W-1:0] req_a_colour,
    output logic              req_a_ready,
    input  logic              req_b_valid,
    input  logic [ADDR_W-1:0] req_b_colour,
    output logic              req_b_ready,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_colour,
    input  logic [DATA_W-1:0] mem_rgb,
    output logic              rsp_a_valid,
    output logic [DATA_W-1:0] rsp_a_rgb,
    output logic              rsp_b_valid,
    output logic [DATA_W-1:0] rsp_b_rgb
);
    import colour_pkg::*;

    req_id_e           r_last_grant;
    logic              r_rsp_a_valid;
    logic              r_rsp_b_valid;
    logic [DATA_W-1:0] r_rsp_a_rgb;
    logic [DATA_W-1:0] r_rsp_b_rgb;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_issue;
    req_id_e           w_issue_id;
    logic              w_tag_valid;
    req_id_e           w_tag_id;
    logic              w_tag_any;
    logic              w_cap_a;
    logic              w_cap_b;

    // Reset gates the grant so ready/address drop the moment rst rises.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!rst && enable) begin
            w_grant_a = req_a_valid && (!req_b_valid || r_last_grant == REQ_B);
            w_grant_b = req_b_valid && (!req_a_valid || r_last_grant == REQ_A);
        end
    end

    assign w_issue    = w_grant_a | w_grant_b;
    assign w_issue_id = w_grant_b ? REQ_B : REQ_A;

    always_comb begin
        mem_colour = '0;
        if (w_grant_a) begin
            mem_colour = req_a_colour;
        end else if (w_grant_b) begin
            mem_colour = req_b_colour;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_B;
        end else if (w_issue) begin
            r_last_grant <= w_issue_id;
        end
    end

    lut_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (w_issue),
        .push_id    (w_issue_id),
        .last_valid (w_tag_valid),
        .last_id    (w_tag_id),
        .any_valid  (w_tag_any)
    );

    assign w_cap_a = w_tag_valid && (w_tag_id == REQ_A);
    assign w_cap_b = w_tag_valid && (w_tag_id == REQ_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_a_valid <= 1'b0;
            r_rsp_b_valid <= 1'b0;
            r_rsp_a_rgb   <= '0;
            r_rsp_b_rgb   <= '0;
        end else begin
            r_rsp_a_valid <= w_cap_a;
            r_rsp_b_valid <= w_cap_b;
            if (w_cap_a) begin
                r_rsp_a_rgb <= mem_rgb;
            end
            if (w_cap_b) begin
                r_rsp_b_rgb <= mem_rgb;
            end
        end
    end

    assign req_a_ready = w_grant_a;
    assign req_b_ready = w_grant_b;
    assign mem_enable  = w_issue | w_tag_any;
    assign rsp_a_valid = r_rsp_a_valid;
    assign rsp_b_valid = r_rsp_b_valid;
    assign rsp_a_rgb   = r_rsp_a_rgb;
    assign rsp_b_rgb   = r_rsp_b_rgb;

endmodule
`default_nettype wire

// File: tb/tb_colour_lut_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_colour_lut_arbiter
//  Description : Directed bench for colour_lut_arbiter at RD_LAT=1 and RD_LAT=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_colour_lut_arbiter;
    import colour_pkg::*;

    localparam int C_LAT1 = 1;
    localparam int C_LAT3 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        en = 1'b0, av = 1'b0, bv = 1'b0, ar, br, me, rav, rbv;
    logic [2:0]  ac = '0, bc = '0, mc;
    logic [23:0] mrgb, rargb, rbrgb;

    logic        en3 = 1'b0, av3 = 1'b0, bv3 = 1'b0, ar3, br3, me3, rav3, rbv3;
    logic [2:0]  ac3 = '0, bc3 = '0, mc3;
    logic [23:0] mrgb3, rargb3, rbrgb3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    colour_lut_arbiter #(.RD_LAT(C_LAT1), .ADDR_W(3), .DATA_W(24)) dut (
        .clk(clk), .rst(rst), .enable(en),
        .req_a_valid(av), .req_a_colour(ac), .req_a_ready(ar),
        .req_b_valid(bv), .req_b_colour(bc), .req_b_ready(br),
        .mem_enable(me), .mem_colour(mc), .mem_rgb(mrgb),
        .rsp_a_valid(rav), .rsp_a_rgb(rargb), .rsp_b_valid(rbv), .rsp_b_rgb(rbrgb)
    );

    colour_lut_arbiter #(.RD_LAT(C_LAT3), .ADDR_W(3), .DATA_W(24)) dut3 (
        .clk(clk), .rst(rst), .enable(en3),
        .req_a_valid(av3), .req_a_colour(ac3), .req_a_ready(ar3),
        .req_b_valid(bv3), .req_b_colour(bc3), .req_b_ready(br3),
        .mem_enable(me3), .mem_colour(mc3), .mem_rgb(mrgb3),
        .rsp_a_valid(rav3), .rsp_a_rgb(rargb3), .rsp_b_valid(rbv3), .rsp_b_rgb(rbrgb3)
    );

    // ROM models: entry i = 24'h111111*i, sampled on the address edge,
    // visible RD_LAT-1 further edges later.
    logic [23:0] rom1 [C_LAT1];
    logic [23:0] rom3 [C_LAT3];
    always @(posedge clk) begin
        if (me) rom1[0] <= 24'h111111 * {21'd0, mc};
        if (me3) begin
            rom3[0] <= 24'h111111 * {21'd0, mc3};
            for (int i = 1; i < C_LAT3; i++) rom3[i] <= rom3[i-1];
        end
    end
    assign mrgb  = rom1[C_LAT1-1];
    assign mrgb3 = rom3[C_LAT3-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        av = 1'b0; bv = 1'b0; av3 = 1'b0; bv3 = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; av = 1'b1; bv = 1'b1; ac = RED; bc = BLUE;
        step(); #1;
        n_checks++; if (ar !== 1'b0 || br !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", ar, br); end
        n_checks++; if (me !== 1'b0 || mc !== 3'd0) begin n_fail++; $display("FAIL reset_mem: got en=%b col=%0d want 0/0", me, mc); end
        n_checks++; if (rav !== 1'b0 || rbv !== 1'b0 || rargb !== 24'h0 || rbrgb !== 24'h0) begin
            n_fail++; $display("FAIL reset_rsp: got %b %b %h %h want 0 0 0 0", rav, rbv, rargb, rbrgb); end
        av = 1'b0; bv = 1'b0; en = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic ea, eb, ra_exp, rb_exp;
        logic [2:0] emc;
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; av = (i < 4); bv = (i < 4); ac = GREEN; bc = MAGENTA;
            #1;
            ea = (i < 4) && (i % 2 == 0);
            eb = (i < 4) && (i % 2 == 1);
            emc = ea ? 3'd2 : (eb ? 3'd5 : 3'd0);
            ra_exp = (i >= 2) && (i % 2 == 0);
            rb_exp = (i >= 2) && (i % 2 == 1);
            n_checks++; if (ar !== ea || br !== eb) begin n_fail++; $display("FAIL cont_grant[%0d]: got a=%b b=%b want a=%b b=%b", i, ar, br, ea, eb); end
            n_checks++; if (mc !== emc) begin n_fail++; $display("FAIL cont_colour[%0d]: got %0d want %0d", i, mc, emc); end
            n_checks++; if (rav !== ra_exp || rbv !== rb_exp) begin n_fail++; $display("FAIL cont_rsp[%0d]: got a=%b b=%b want a=%b b=%b", i, rav, rbv, ra_exp, rb_exp); end
            if (ra_exp) begin
                n_checks++; if (rargb !== 24'h222222) begin n_fail++; $display("FAIL cont_rgb_a[%0d]: got %h want 222222", i, rargb); end
            end
            if (rb_exp) begin
                n_checks++; if (rbrgb !== 24'h555555) begin n_fail++; $display("FAIL cont_rgb_b[%0d]: got %h want 555555", i, rbrgb); end
            end
            step();
        end
        idle(2);
    endtask

    task automatic test_enable_gate();
        en = 1'b0; av = 1'b1; bv = 1'b1; ac = GREEN; bc = MAGENTA;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (ar !== 1'b0 || br !== 1'b0 || me !== 1'b0) begin
                n_fail++; $display("FAIL gate_off[%0d]: got ra=%b rb=%b me=%b want 0 0 0", i, ar, br, me); end
            step();
        end
        en = 1'b1;
        #1;
        n_checks++; if (ar !== 1'b1 || br !== 1'b0 || mc !== 3'd2) begin
            n_fail++; $display("FAIL gate_on_first: got ra=%b rb=%b col=%0d want 1 0 2", ar, br, mc); end
        step();
        idle(3);
    endtask

    task automatic test_single_a();
        en = 1'b1; av = 1'b1; ac = RED;
        #1;
        n_checks++; if (ar !== 1'b1 || br !== 1'b0 || mc !== 3'd4 || me !== 1'b1) begin
            n_fail++; $display("FAIL single_issue: got ra=%b rb=%b col=%0d me=%b want 1 0 4 1", ar, br, mc, me); end
        step();
        av = 1'b0;
        n_checks++; if (rav !== 1'b0 || me !== 1'b1) begin n_fail++; $display("FAIL single_inflight: got rsp=%b me=%b want 0 1", rav, me); end
        step();
        n_checks++; if (rav !== 1'b1 || rbv !== 1'b0 || rargb !== 24'h444444) begin
            n_fail++; $display("FAIL single_rsp: got va=%b vb=%b rgb=%h want 1 0 444444", rav, rbv, rargb); end
        n_checks++; if (me !== 1'b0) begin n_fail++; $display("FAIL single_me_idle: got %b want 0", me); end
        step();
        n_checks++; if (rav !== 1'b0 || rargb !== 24'h444444) begin n_fail++; $display("FAIL single_hold: got v=%b rgb=%h want 0 444444", rav, rargb); end
        idle(2);
    endtask

    task automatic test_enable_drop();
        en = 1'b1; av = 1'b1; bv = 1'b1; ac = CYAN; bc = YELLOW;
        #1;
        n_checks++; if (br !== 1'b1 || mc !== 3'd6) begin n_fail++; $display("FAIL drop_first: got rb=%b col=%0d want 1 6", br, mc); end
        step();
        n_checks++; if (ar !== 1'b1 || mc !== 3'd3) begin n_fail++; $display("FAIL drop_second: got ra=%b col=%0d want 1 3", ar, mc); end
        step();
        en = 1'b0;
        #1;
        n_checks++; if (ar !== 1'b0 || br !== 1'b0 || mc !== 3'd0 || me !== 1'b1) begin
            n_fail++; $display("FAIL drop_stop: got ra=%b rb=%b col=%0d me=%b want 0 0 0 1", ar, br, mc, me); end
        n_checks++; if (rbv !== 1'b1 || rbrgb !== 24'h666666) begin n_fail++; $display("FAIL drop_rsp_b: got v=%b rgb=%h want 1 666666", rbv, rbrgb); end
        step();
        n_checks++; if (rav !== 1'b1 || rbv !== 1'b0 || rargb !== 24'h333333) begin
            n_fail++; $display("FAIL drop_rsp_a: got va=%b vb=%b rgb=%h want 1 0 333333", rav, rbv, rargb); end
        n_checks++; if (me !== 1'b0) begin n_fail++; $display("FAIL drop_me: got %b want 0", me); end
        step();
        n_checks++; if (rav !== 1'b0 || rbv !== 1'b0) begin n_fail++; $display("FAIL drop_quiet: got %b %b want 0 0", rav, rbv); end
        idle(2);
    endtask

    task automatic test_rdlat3();
        logic ev, em;
        en3 = 1'b1; bv3 = 1'b1; bc3 = WHITE;
        #1;
        n_checks++; if (br3 !== 1'b1 || mc3 !== 3'd7) begin n_fail++; $display("FAIL lat3_issue: got rb=%b col=%0d want 1 7", br3, mc3); end
        step();
        bv3 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ev = (i == 4);
            em = (i <= 3);
            n_checks++; if (rbv3 !== ev || me3 !== em) begin
                n_fail++; $display("FAIL lat3_cycle[%0d]: got v=%b me=%b want %b %b", i, rbv3, me3, ev, em); end
            if (ev) begin
                n_checks++; if (rbrgb3 !== 24'h777777) begin n_fail++; $display("FAIL lat3_rgb: got %h want 777777", rbrgb3); end
            end
            step();
        end
        en3 = 1'b0;
        idle(1);
    endtask

    task automatic test_reset_mid();
        en = 1'b1; av = 1'b1; ac = BLUE;
        #1;
        n_checks++; if (ar !== 1'b1) begin n_fail++; $display("FAIL rmid_issue: got %b want 1", ar); end
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (ar !== 1'b0 || me !== 1'b0 || mc !== 3'd0) begin
            n_fail++; $display("FAIL rmid_comb: got ra=%b me=%b col=%0d want 0 0 0", ar, me, mc); end
        n_checks++; if (rargb !== 24'h0 || rbrgb !== 24'h0 || rbrgb3 !== 24'h0) begin
            n_fail++; $display("FAIL rmid_rgb: got %h %h %h want 0 0 0", rargb, rbrgb, rbrgb3); end
        av = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (rav !== 1'b0 || rbv !== 1'b0) begin n_fail++; $display("FAIL rmid_no_rsp[%0d]: got %b %b want 0 0", i, rav, rbv); end
        end
        av = 1'b1; bv = 1'b1; ac = GREEN; bc = MAGENTA;
        #1;
        n_checks++; if (ar !== 1'b1 || br !== 1'b0) begin n_fail++; $display("FAIL rmid_rr_reset: got ra=%b rb=%b want 1 0", ar, br); end
        step();
        idle(3);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_enable_gate();
        test_single_a();
        test_enable_drop();
        test_rdlat3();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
